// File: rtl/uart_bus_master_pkg.sv
// uart_bus_master_pkg
//   Shared constants and state encodings for the UART bus master slice.
//   - Command/response byte codes seen on the UART link.
//   - Main FSM state encoding (3 bits).
//   - TX handshake sub-FSM encoding.
package uart_bus_master_pkg;

    localparam logic [7:0] CMD_WR  = 8'h57;
    localparam logic [7:0] CMD_RD  = 8'h52;
    localparam logic [7:0] RSP_ACK = 8'h06;
    localparam logic [7:0] RSP_NAK = 8'h15;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        DATA,
        REQ,
        ACCESS,
        RESP,
        TX_ACC,
        TX_DONE
    } state_t;

    typedef enum logic [1:0] {
        HS_IDLE,   // nothing in flight
        HS_WAIT,   // byte loaded, waiting for sender idle
        HS_EN,     // tx_en held until sender goes busy
        HS_DRAIN   // waiting for sender to finish shifting
    } hs_state_t;

endpackage

// File: rtl/uart_bus_master_if.sv
// uart_bus_master_if
//   Single-cycle peripheral bus as seen by an initiator.
//   master: drives bus_req, rd, wr, addr, wdata; samples bus_gnt, rdata.
//   slave : the arbiter/peripheral side (grant + combinational read data).
interface uart_bus_master_if;
    logic        bus_req;
    logic        bus_gnt;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (
        output bus_req, rd, wr, addr, wdata,
        input  bus_gnt, rdata
    );

    modport slave (
        input  bus_req, rd, wr, addr, wdata,
        output bus_gnt, rdata
    );
endinterface

// File: rtl/uart_bus_master_tx_handshake.sv
// uart_tx_handshake
//   Hands one byte to the UART sender: wait for idle, raise tx_en until the
//   sender goes busy, then wait for it to become idle again.
//   Ports:
//     clk, reset   clock, async active-low reset
//     load         pulse: a byte is ready on tx_data (held by the caller)
//     tx_status    sender idle flag (1 = idle)
//     tx_en        send request to the sender
//     accepted     pulse: sender took the byte (went busy while tx_en=1)
//     done         pulse: sender idle again after the byte
module uart_tx_handshake
    import uart_bus_master_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic tx_status,
    output logic tx_en,
    output logic accepted,
    output logic done
);

    hs_state_t hs, hs_n;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) hs <= HS_IDLE;
        else        hs <= hs_n;
    end

    always_comb begin
        hs_n     = hs;
        tx_en    = 1'b0;
        accepted = 1'b0;
        done     = 1'b0;
        case (hs)
            HS_IDLE:  if (load) hs_n = HS_WAIT;
            HS_WAIT:  if (tx_status) hs_n = HS_EN;
            HS_EN: begin
                tx_en = 1'b1;
                if (!tx_status) begin
                    accepted = 1'b1;
                    hs_n     = HS_DRAIN;
                end
            end
            HS_DRAIN: if (tx_status) begin
                done = 1'b1;
                hs_n = HS_IDLE;
            end
            default:  hs_n = HS_IDLE;
        endcase
    end

endmodule

// File: rtl/uart_bus_master.sv
// uart_bus_master
//   Decodes UART command frames (write 0x57 + A[4] + D[4], read 0x52 + A[4]),
//   performs one bus access after grant and answers over the UART sender
//   (ACK, NAK, or four read-data bytes MSB first).
//   Ports:
//     clk, reset            clock, async active-low reset
//     rx_data, rx_status    receiver byte and valid level (byte on rising edge)
//     tx_data, tx_en        byte and send request to the sender
//     tx_status             sender idle flag
//     bif (master)          bus_req/bus_gnt/rd/wr/addr/wdata/rdata
//     busy                  high whenever not IDLE
module uart_bus_master
    import uart_bus_master_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int TO_W           = 20
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [7:0]                rx_data,
    input  logic                      rx_status,
    output logic [7:0]                tx_data,
    output logic                      tx_en,
    input  logic                      tx_status,
    uart_bus_master_if.master         bif,
    output logic                      busy
);

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    state_t          state, state_n;
    logic            rx_q;
    logic            byte_stb;
    logic            is_wr;
    logic [1:0]      byte_cnt;
    logic [1:0]      rsp_left;     // response bytes still to send after the current one
    logic [31:0]     rsp_sr;       // response bytes, next one in [31:24]
    logic [TO_W-1:0] to_cnt;
    logic [31:0]     addr_r, wdata_r;
    logic            ld_nak, ld_ack, hs_load;
    logic            hs_acc, hs_done;

    assign byte_stb = rx_status & ~rx_q;

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_n;
    end

    // ---------------- next state / decode ----------------
    always_comb begin
        state_n = state;
        ld_nak  = 1'b0;
        ld_ack  = 1'b0;
        hs_load = 1'b0;
        case (state)
            IDLE: if (byte_stb) begin
                if (rx_data == CMD_WR || rx_data == CMD_RD) begin
                    state_n = ADDR;
                end else begin
                    state_n = RESP;
                    ld_nak  = 1'b1;
                end
            end
            // A byte in the same cycle as expiry takes priority.
            ADDR: if (byte_stb) begin
                if (byte_cnt == 2'd3) begin
                    if (is_wr) begin
                        state_n = DATA;
                    end else if (rx_data[1:0] != 2'b00) begin
                        state_n = RESP;
                        ld_nak  = 1'b1;
                    end else begin
                        state_n = REQ;
                    end
                end
            end else if (to_cnt == TO_LAST) begin
                state_n = IDLE;
            end
            DATA: if (byte_stb) begin
                if (byte_cnt == 2'd3) begin
                    if (addr_r[1:0] != 2'b00) begin
                        state_n = RESP;
                        ld_nak  = 1'b1;
                    end else begin
                        state_n = REQ;
                    end
                end
            end else if (to_cnt == TO_LAST) begin
                state_n = IDLE;
            end
            REQ:     if (bif.bus_gnt) state_n = ACCESS;
            ACCESS: begin
                state_n = RESP;
                ld_ack  = is_wr;
            end
            RESP: begin
                hs_load = 1'b1;
                state_n = TX_ACC;
            end
            TX_ACC:  if (hs_acc) state_n = TX_DONE;
            TX_DONE: if (hs_done) state_n = (rsp_left == 2'd0) ? IDLE : RESP;
            default: state_n = IDLE;
        endcase
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_q     <= 1'b0;
            is_wr    <= 1'b0;
            byte_cnt <= 2'd0;
            rsp_left <= 2'd0;
            rsp_sr   <= 32'h0;
            to_cnt   <= '0;
            addr_r   <= 32'h0;
            wdata_r  <= 32'h0;
            tx_data  <= 8'h0;
        end else begin
            rx_q <= rx_status;

            if ((state == ADDR || state == DATA) && !byte_stb) to_cnt <= to_cnt + TO_W'(1);
            else                                               to_cnt <= '0;

            if (state == IDLE && byte_stb) begin
                is_wr    <= (rx_data == CMD_WR);
                byte_cnt <= 2'd0;
            end
            // byte_cnt wraps 3->0, so DATA starts counting from zero
            if (state == ADDR && byte_stb) begin
                addr_r   <= {addr_r[23:0], rx_data};
                byte_cnt <= byte_cnt + 2'd1;
            end
            if (state == DATA && byte_stb) begin
                wdata_r  <= {wdata_r[23:0], rx_data};
                byte_cnt <= byte_cnt + 2'd1;
            end

            if (ld_nak) begin
                rsp_sr   <= {RSP_NAK, 24'h0};
                rsp_left <= 2'd0;
            end else if (ld_ack) begin
                rsp_sr   <= {RSP_ACK, 24'h0};
                rsp_left <= 2'd0;
            end else if (state == ACCESS && !is_wr) begin
                rsp_sr   <= bif.rdata;
                rsp_left <= 2'd3;
            end else if (state == RESP) begin
                tx_data <= rsp_sr[31:24];
                rsp_sr  <= {rsp_sr[23:0], 8'h0};
            end else if (state == TX_DONE && hs_done && rsp_left != 2'd0) begin
                rsp_left <= rsp_left - 2'd1;
            end
        end
    end

    uart_tx_handshake u_tx_hs (
        .clk       (clk),
        .reset     (reset),
        .load      (hs_load),
        .tx_status (tx_status),
        .tx_en     (tx_en),
        .accepted  (hs_acc),
        .done      (hs_done)
    );

    assign bif.bus_req = (state == REQ) || (state == ACCESS);
    assign bif.rd      = (state == ACCESS) && !is_wr;
    assign bif.wr      = (state == ACCESS) &&  is_wr;
    assign bif.addr    = addr_r;
    assign bif.wdata   = wdata_r;
    assign busy        = (state != IDLE);

endmodule

// File: doc/uart_bus_master.md
Name: uart_bus_master

Overview:
- UART-driven initiator on the single-cycle rd/wr/addr/wdata/rdata bus that memory-mapped peripherals respond on.
- Takes bytes from the existing UART receiver and decodes read/write command frames.
- Runs one bus access per frame, after bus grant, and returns the result through the existing UART sender.
- Used for board bring-up: poke the LED, digit and timer registers, or load memory without the CPU.

Parameters:
TIMEOUT_CYCLES, 1000000, maximum clk cycles between bytes within one frame before the frame is aborted.
TO_W, 20, width of the timeout counter; must satisfy 2^TO_W > TIMEOUT_CYCLES.

Ports:
clk  input  1  system clock; all state changes on posedge.
reset  input  1  asynchronous, active-low reset.
rx_data  input  8  byte from the UART receiver.
rx_status  input  1  receiver valid level; a new byte is signalled by a rising edge.
tx_data  output  8  byte presented to the UART sender.
tx_en  output  1  send request to the UART sender.
tx_status  input  1  sender idle flag; 1 = idle, 0 = shifting.
bus_req  output  1  request for bus ownership.
bus_gnt  input  1  bus grant from the arbiter.
rd  output  1  bus read strobe, one cycle.
wr  output  1  bus write strobe, one cycle.
addr  output  32  bus address.
wdata  output  32  bus write data.
rdata  input  32  bus read data, combinational and valid in the same cycle as rd.
busy  output  1  high whenever the state is not IDLE.

Behaviour:
- Reset: all outputs are 0 (tx_data, tx_en, bus_req, rd, wr, addr, wdata, busy). State is IDLE. Counters and the rx edge register are cleared. Reset asserted mid-frame or mid-send aborts immediately; no response byte is sent.
- RX byte acceptance: register rx_status. A byte is taken on the cycle where rx_status=1 and its registered copy=0. One byte is accepted per rising edge. Edges that arrive in bus or TX states are ignored (dropped).
- Frame formats, all multi-byte fields MSB first:
  - Write: 0x57, A3, A2, A1, A0, D3, D2, D1, D0. Response is ACK 0x06.
  - Read: 0x52, A3..A0. Response is R3, R2, R1, R0.
  - Any other first byte: respond NAK 0x15 and return to IDLE.
- Alignment: if addr[1:0] != 0 after the frame completes, no bus access is made and NAK is sent. For a write, this check happens after all data bytes are received.
- State machine:
  - IDLE: on a byte, go to ADDR for 0x57/0x52, otherwise go to RESP with NAK.
  - ADDR: shift 4 bytes into addr; then go to DATA (write) or REQ (read).
  - DATA: shift 4 bytes into wdata, then go to REQ.
  - REQ: bus_req=1 and held; wait for bus_gnt. On the first cycle with bus_gnt=1, go to ACCESS.
  - ACCESS: exactly one cycle with rd or wr=1 while bus_req=1 and bus_gnt=1. On a read, capture rdata into a 32-bit shift register. bus_req drops the next cycle.
  - If bus_gnt falls during ACCESS, the access still counts; the arbiter must hold the grant while bus_req=1.
  - RESP: load tx_data with the next response byte (1 byte for ACK/NAK, 4 bytes for read).
  - TX_ACC: wait for tx_status=1. Then assert tx_en=1 and hold it until tx_status=0 is seen (sender accepted); then drop tx_en.
  - TX_DONE: wait for tx_status=1. If more bytes remain, return to RESP; otherwise go to IDLE.
- Byte counter: 2 bits, wraps 3->0 to mark field completion. A separate count tracks response bytes remaining.
- Timeout: the counter resets on every accepted byte and counts only in ADDR and DATA. When it reaches TIMEOUT_CYCLES, go to IDLE silently; addr and wdata keep their partial values.
- Latency: last frame byte edge -> REQ in 1 cycle. gnt -> rd/wr next cycle. First tx_en no earlier than 1 cycle after ACCESS.
- Simultaneous rx edge and timeout expiry in the same cycle: the byte wins.
- addr and wdata hold their values outside ACCESS. rd and wr are never both high.

Decomposition:
- Shared package holds:
  - constants CMD_WR=8'h57, CMD_RD=8'h52, RSP_ACK=8'h06, RSP_NAK=8'h15;
  - the state encoding, 3 bits: IDLE, ADDR, DATA, REQ, ACCESS, RESP, TX_ACC, TX_DONE.
- One natural sub-module: uart_tx_handshake. It implements the TX_ACC/TX_DONE byte handshake with tx_status, exposing load/done to the main FSM.

Test Plan:
1. Write frame 57 40 00 00 0C 00 00 00 A5 with gnt tied 1 -> one-cycle wr with addr=0x4000000C, wdata=0x000000A5; exactly one tx byte 0x06.
2. Read frame 52 40 00 00 10 with rdata=0x0000003C while rd -> one-cycle rd at 0x40000010; tx bytes 00 00 00 3C in order, each started only after tx_status returned to 1.
3. Byte 0x41 in IDLE -> no bus activity; tx 0x15; busy returns to 0.
4. Read frame 52 40 00 00 02 -> no rd; tx 0x15.
5. Write frame with bus_gnt held 0 for 50 cycles -> bus_req high for all 50 cycles, wr=0 throughout; wr pulses 1 cycle after gnt rises; ACK follows.
6. Send 57 40 00 then idle for TIMEOUT_CYCLES (TIMEOUT_CYCLES set to 100) -> IDLE at cycle 100, no tx_en. A following valid read frame completes normally. Separately, assert reset mid-read-response -> tx_en=0 and busy=0 immediately.
